// File: rtl/execute_shift_arbiter.sv
// execute_shift_arbiter
// Shares one combinational execute_shift unit between two requesters:
// A (main issue slot, source 0) and B (secondary/microcode slot, source 1).
// Each requester has a one-entry holding register. A round-robin arbiter picks
// one pending operation per cycle, and a registered output stage captures the
// shifter result and flags under valid/busy backpressure.
// Optional build macro: EXECUTE_SHIFT_ARB_FIXED_PRIO_EN
//   defined   -> A always wins when both are pending (no round-robin state)
//   undefined -> round-robin between A and B (default)
module execute_shift_arbiter #(
  parameter int P_N = 32
) (
  input  logic           iCLOCK,
  input  logic           iRESET,
  input  logic           iRESET_SYNC,
  // requester A
  input  logic           iREQ_A_VALID,
  output logic           oREQ_A_BUSY,
  input  logic [2:0]     iREQ_A_MODE,
  input  logic [P_N-1:0] iREQ_A_DATA_0,
  input  logic [P_N-1:0] iREQ_A_DATA_1,
  // requester B
  input  logic           iREQ_B_VALID,
  output logic           oREQ_B_BUSY,
  input  logic [2:0]     iREQ_B_MODE,
  input  logic [P_N-1:0] iREQ_B_DATA_0,
  input  logic [P_N-1:0] iREQ_B_DATA_1,
  // shared shifter
  output logic [2:0]     oSHIFT_MODE,
  output logic [P_N-1:0] oSHIFT_DATA_0,
  output logic [P_N-1:0] oSHIFT_DATA_1,
  input  logic [P_N-1:0] iSHIFT_DATA,
  input  logic           iSHIFT_SF,
  input  logic           iSHIFT_OF,
  input  logic           iSHIFT_CF,
  input  logic           iSHIFT_PF,
  input  logic           iSHIFT_ZF,
  // result stage
  output logic           oOUT_VALID,
  input  logic           iOUT_BUSY,
  output logic           oOUT_SOURCE,
  output logic [P_N-1:0] oOUT_DATA,
  output logic [4:0]     oOUT_FLAGS
);

  // Requests gathered into per-slot arrays: index 0 = A, index 1 = B.
  logic [1:0]     w_req_valid;
  logic [2:0]     w_req_mode   [2];
  logic [P_N-1:0] w_req_data_0 [2];
  logic [P_N-1:0] w_req_data_1 [2];

  assign w_req_valid     = {iREQ_B_VALID, iREQ_A_VALID};
  assign w_req_mode[0]   = iREQ_A_MODE;
  assign w_req_mode[1]   = iREQ_B_MODE;
  assign w_req_data_0[0] = iREQ_A_DATA_0;
  assign w_req_data_0[1] = iREQ_B_DATA_0;
  assign w_req_data_1[0] = iREQ_A_DATA_1;
  assign w_req_data_1[1] = iREQ_B_DATA_1;

  // Holding registers, one entry per source.
  logic [1:0]     r_pend_valid;
  logic [2:0]     r_pend_mode   [2];
  logic [P_N-1:0] r_pend_data_0 [2];
  logic [P_N-1:0] r_pend_data_1 [2];

  // Output stage.
  logic           r_out_valid;
  logic           r_out_source;
  logic [P_N-1:0] r_out_data;
  logic [4:0]     r_out_flags;

  logic           w_out_load;
  logic           w_prefer_b;
  logic [1:0]     w_grant;
  logic [1:0]     w_busy;
  logic [1:0]     w_accept;
  logic           w_sel;

  // The output register can take a new result when empty or being drained.
  assign w_out_load = !r_out_valid || !iOUT_BUSY;

`ifdef EXECUTE_SHIFT_ARB_FIXED_PRIO_EN
  // Fixed priority: A wins every tie, so no fairness state is kept.
  assign w_prefer_b = 1'b0;
`else
  // r_rr = 1 means B wins the next tie.
  logic r_rr;
  assign w_prefer_b = r_rr;

  // Round-robin pointer: after a grant, the other source gets the next tie.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_rr <= 1'b0;
    end else if (iRESET_SYNC) begin
      r_rr <= 1'b0;
    end else if (w_grant[0]) begin
      r_rr <= 1'b1;
    end else if (w_grant[1]) begin
      r_rr <= 1'b0;
    end
  end
`endif

  // Arbitration: only grant when the output register can accept the result.
  always_comb begin
    w_grant = 2'b00;
    if (w_out_load) begin
      if (r_pend_valid[0] && r_pend_valid[1]) begin
        if (w_prefer_b) begin
          w_grant[1] = 1'b1;
        end else begin
          w_grant[0] = 1'b1;
        end
      end else if (r_pend_valid[0]) begin
        w_grant[0] = 1'b1;
      end else if (r_pend_valid[1]) begin
        w_grant[1] = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      // A granted slot frees up in the same cycle, so a source granted every
      // cycle can issue back-to-back. A flush blocks all new requests.
      assign w_busy[gi]   = iRESET_SYNC || (r_pend_valid[gi] && !w_grant[gi]);
      assign w_accept[gi] = w_req_valid[gi] && !w_busy[gi];

      // Holding register: capture on accept, release on grant, drop on flush.
      always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
          r_pend_valid[gi]  <= 1'b0;
          r_pend_mode[gi]   <= 3'd0;
          r_pend_data_0[gi] <= '0;
          r_pend_data_1[gi] <= '0;
        end else if (iRESET_SYNC) begin
          r_pend_valid[gi]  <= 1'b0;
        end else if (w_accept[gi]) begin
          r_pend_valid[gi]  <= 1'b1;
          r_pend_mode[gi]   <= w_req_mode[gi];
          r_pend_data_0[gi] <= w_req_data_0[gi];
          r_pend_data_1[gi] <= w_req_data_1[gi];
        end else if (w_grant[gi]) begin
          r_pend_valid[gi]  <= 1'b0;
        end
      end
    end
  endgenerate

  assign oREQ_A_BUSY = w_busy[0];
  assign oREQ_B_BUSY = w_busy[1];

  // Shifter operands come from the granted slot; from A when nothing is granted.
  assign w_sel         = w_grant[1];
  assign oSHIFT_MODE   = r_pend_mode[w_sel];
  assign oSHIFT_DATA_0 = r_pend_data_0[w_sel];
  assign oSHIFT_DATA_1 = r_pend_data_1[w_sel];

  // Output stage: load the shifter result on a grant, empty when drained.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_out_valid  <= 1'b0;
      r_out_source <= 1'b0;
      r_out_data   <= '0;
      r_out_flags  <= 5'd0;
    end else if (iRESET_SYNC) begin
      r_out_valid  <= 1'b0;
      r_out_source <= 1'b0;
      r_out_data   <= '0;
      r_out_flags  <= 5'd0;
    end else if (|w_grant) begin
      r_out_valid  <= 1'b1;
      r_out_source <= w_grant[1];
      r_out_data   <= iSHIFT_DATA;
      r_out_flags  <= {iSHIFT_SF, iSHIFT_OF, iSHIFT_CF, iSHIFT_PF, iSHIFT_ZF};
    end else if (w_out_load) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign oOUT_VALID  = r_out_valid;
  assign oOUT_SOURCE = r_out_source;
  assign oOUT_DATA   = r_out_data;
  assign oOUT_FLAGS  = r_out_flags;

endmodule

// File: tb/tb_execute_shift_arbiter.sv
// Testbench for execute_shift_arbiter: directed scenarios plus randomized
// traffic checked against a queue-based reference model. A behavioural shifter
// stub stands in for the shared execute_shift unit.
module tb_execute_shift_arbiter;
  localparam int N = 32;

  typedef struct packed {
    logic [2:0]   mode;
    logic [N-1:0] d0;
    logic [N-1:0] d1;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, rst_sync, out_busy;
  logic         a_valid, b_valid;
  logic [2:0]   a_mode, b_mode;
  logic [N-1:0] a_d0, a_d1, b_d0, b_d1;
  logic         a_busy, b_busy;
  logic [2:0]   sh_mode;
  logic [N-1:0] sh_d0, sh_d1, sh_data;
  logic         sh_sf, sh_of, sh_cf, sh_pf, sh_zf;
  logic         out_valid, out_source;
  logic [N-1:0] out_data;
  logic [4:0]   out_flags;
  logic [36:0]  sh_res;

  int total = 0;
  int bad   = 0;

  // Shifter behaviour: returns {SF, OF, CF, PF, ZF, result}.
  function automatic logic [36:0] shift_ref(input logic [2:0] m, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned n;
    int unsigned k;
    logic [31:0] r;
    n = int'(b[5:0]);
    k = n % 32;
    case (m)
      3'd1:    r = (n >= 32) ? 32'd0 : (a << n);
      3'd2:    r = (n >= 32) ? 32'd0 : (a >> n);
      3'd3:    r = (n >= 32) ? {32{a[31]}} : 32'($signed(a) >>> n);
      3'd4:    r = (a << k) | (a >> ((32 - k) % 32));
      3'd5:    r = (a >> k) | (a << ((32 - k) % 32));
      default: r = a;
    endcase
    return {r[31], a[31] ^ r[31], a[0], ~^r[7:0], (r == 32'd0), r};
  endfunction

  assign sh_res  = shift_ref(sh_mode, sh_d0, sh_d1);
  assign sh_data = sh_res[31:0];
  assign sh_sf   = sh_res[36];
  assign sh_of   = sh_res[35];
  assign sh_cf   = sh_res[34];
  assign sh_pf   = sh_res[33];
  assign sh_zf   = sh_res[32];

  execute_shift_arbiter #(.P_N(N)) dut (
    .iCLOCK(clk), .iRESET(rst), .iRESET_SYNC(rst_sync),
    .iREQ_A_VALID(a_valid), .oREQ_A_BUSY(a_busy), .iREQ_A_MODE(a_mode),
    .iREQ_A_DATA_0(a_d0), .iREQ_A_DATA_1(a_d1),
    .iREQ_B_VALID(b_valid), .oREQ_B_BUSY(b_busy), .iREQ_B_MODE(b_mode),
    .iREQ_B_DATA_0(b_d0), .iREQ_B_DATA_1(b_d1),
    .oSHIFT_MODE(sh_mode), .oSHIFT_DATA_0(sh_d0), .oSHIFT_DATA_1(sh_d1),
    .iSHIFT_DATA(sh_data), .iSHIFT_SF(sh_sf), .iSHIFT_OF(sh_of),
    .iSHIFT_CF(sh_cf), .iSHIFT_PF(sh_pf), .iSHIFT_ZF(sh_zf),
    .oOUT_VALID(out_valid), .iOUT_BUSY(out_busy), .oOUT_SOURCE(out_source),
    .oOUT_DATA(out_data), .oOUT_FLAGS(out_flags)
  );

  // ---------------- reference model ----------------
  op_t          q_a[$];
  op_t          q_b[$];
  bit           m_rr_b, m_valid, m_src, m_ga, m_gb, m_busy_a, m_busy_b;
  logic [N-1:0] m_data;
  logic [4:0]   m_flags;

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    m_rr_b = 1'b0; m_valid = 1'b0; m_src = 1'b0;
    m_data = '0;   m_flags = 5'd0;
    m_ga = 1'b0;   m_gb = 1'b0; m_busy_a = 1'b0; m_busy_b = 1'b0;
  endtask

  // Decide this cycle's grants and busy from the current inputs.
  task automatic model_comb();
    bit load, pa, pb, prefer_b;
    load = !m_valid || !out_busy;
    pa = (q_a.size() != 0);
    pb = (q_b.size() != 0);
`ifdef EXECUTE_SHIFT_ARB_FIXED_PRIO_EN
    prefer_b = 1'b0;
`else
    prefer_b = m_rr_b;
`endif
    m_ga = load && pa && !(pb && prefer_b);
    m_gb = load && pb && !(pa && !prefer_b);
    m_busy_a = rst_sync || (pa && !m_ga);
    m_busy_b = rst_sync || (pb && !m_gb);
  endtask

  // Advance the model across one rising edge.
  task automatic model_edge();
    op_t g;
    logic [36:0] r;
    if (rst_sync) begin
      model_reset();
      return;
    end
    if (m_ga || m_gb) begin
      g = m_ga ? q_a.pop_front() : q_b.pop_front();
      r = shift_ref(g.mode, g.d0, g.d1);
      m_valid = 1'b1; m_src = m_gb; m_data = r[31:0]; m_flags = r[36:32];
      m_rr_b = m_ga;
    end else if (!m_valid || !out_busy) begin
      m_valid = 1'b0;
    end
    if (a_valid && !m_busy_a) q_a.push_back('{a_mode, a_d0, a_d1});
    if (b_valid && !m_busy_b) q_b.push_back('{b_mode, b_d0, b_d1});
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.mode = 3'($urandom_range(0, 5));
    o.d0   = $urandom;
    o.d1   = 32'($urandom_range(0, 63));
    if ($urandom_range(0, 7) == 0) o.d1 = $urandom;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_valid = 0; b_valid = 0; out_busy = 0; rst_sync = 0;
    a_mode = 0; a_d0 = 0; a_d1 = 0; b_mode = 0; b_d0 = 0; b_d1 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    tick();
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2 rst = 0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if ({out_source, out_flags} !== 6'd0) begin bad++; $display("FAIL reset_src_flags got=%b exp=0", {out_source, out_flags}); end
    total++; if ({a_busy, b_busy} !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", {a_busy, b_busy}); end
    // Get a result into the output, then stall it with both slots pending.
    a_valid = 1; a_mode = 3'd1; a_d0 = 32'h3; a_d1 = 32'd1;
    tick(); a_valid = 0;
    tick();
    out_busy = 1;
    a_valid = 1; a_mode = 3'd2; a_d0 = 32'h100; a_d1 = 32'd4;
    b_valid = 1; b_mode = 3'd0; b_d0 = 32'h55; b_d1 = 32'd0;
    tick(); a_valid = 0; b_valid = 0;
    #1;
    total++; if ({a_busy, b_busy} !== 2'b11) begin bad++; $display("FAIL pre_reset_busy got=%b exp=11", {a_busy, b_busy}); end
    #2 rst = 1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%b exp=0", out_valid); end
    total++; if ({out_data, out_flags, out_source} !== 38'd0) begin bad++; $display("FAIL async_reset_out got=%h exp=0", {out_data, out_flags, out_source}); end
    total++; if ({a_busy, b_busy} !== 2'b00) begin bad++; $display("FAIL async_reset_busy got=%b exp=00", {a_busy, b_busy}); end
    @(posedge clk);
    #2 rst = 0; out_busy = 0;
    a_valid = 1; a_mode = 3'd1; a_d0 = 32'h1; a_d1 = 32'd4;
    tick(); a_valid = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL first_latency1 got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'h10) begin bad++; $display("FAIL first_data got=%h exp=00000010", out_data); end
    total++; if (out_source !== 1'b0) begin bad++; $display("FAIL first_src got=%b exp=0", out_source); end
  endtask

  task automatic test_contention();
    do_reset();
    a_valid = 1; a_mode = 3'd2; a_d0 = 32'h8000_0000; a_d1 = 32'd31;
    b_valid = 1; b_mode = 3'd3; b_d0 = 32'h8000_0000; b_d1 = 32'd4;
    #1;
    total++; if ({a_busy, b_busy} !== 2'b00) begin bad++; $display("FAIL cont_accept_busy got=%b exp=00", {a_busy, b_busy}); end
    tick();
    a_mode = 3'd1; a_d0 = 32'h3; a_d1 = 32'd2;   // second A op, B held
    #1;
    total++; if ({a_busy, b_busy} !== 2'b01) begin bad++; $display("FAIL cont_busy got=%b exp=01", {a_busy, b_busy}); end
    tick(); a_valid = 0; b_valid = 0;
    total++; if ({out_valid, out_source, out_data} !== {2'b10, 32'h1}) begin bad++; $display("FAIL cont_first got=%b/%b/%h exp=1/0/00000001", out_valid, out_source, out_data); end
    tick();
    total++; if ({out_valid, out_source, out_data} !== {2'b11, 32'hF800_0000}) begin bad++; $display("FAIL cont_second got=%b/%b/%h exp=1/1/f8000000", out_valid, out_source, out_data); end
    total++; if (out_flags[4] !== 1'b1) begin bad++; $display("FAIL cont_sf got=%b exp=1", out_flags[4]); end
    tick();
    total++; if ({out_valid, out_source, out_data} !== {2'b10, 32'hC}) begin bad++; $display("FAIL cont_third got=%b/%b/%h exp=1/0/0000000c", out_valid, out_source, out_data); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cont_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_valid = 1; a_mode = 3'd5; a_d0 = 32'h1; a_d1 = 32'd1;          // ROR -> 0x80000000
    tick();
    a_mode = 3'd4; a_d0 = 32'h8000_0000; a_d1 = 32'd4;               // ROL -> 0x00000008
    tick(); a_valid = 0; out_busy = 1;
    total++; if (out_data !== 32'h8000_0000) begin bad++; $display("FAIL bp_first got=%h exp=80000000", out_data); end
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL bp_busy[%0d] got=%b exp=1", i, a_busy); end
      total++; if ({out_valid, out_data} !== {1'b1, 32'h8000_0000}) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/80000000", i, out_valid, out_data); end
      tick();
    end
    out_busy = 0;
    #1;
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL bp_release_busy got=%b exp=0", a_busy); end
    tick();
    total++; if ({out_valid, out_source, out_data} !== {2'b10, 32'h8}) begin bad++; $display("FAIL bp_next got=%b/%b/%h exp=1/0/00000008", out_valid, out_source, out_data); end
  endtask

  task automatic test_flush();
    do_reset();
    a_valid = 1; a_mode = 3'd1; a_d0 = 32'h1; a_d1 = 32'd1;
    tick(); a_valid = 0;
    tick(); out_busy = 1;
    a_valid = 1; a_mode = 3'd0; a_d0 = 32'hAAAA; a_d1 = 0;
    b_valid = 1; b_mode = 3'd0; b_d0 = 32'hBBBB; b_d1 = 0;
    tick(); a_valid = 0; b_valid = 0;
    rst_sync = 1;
    #1;
    total++; if ({a_busy, b_busy} !== 2'b11) begin bad++; $display("FAIL flush_busy_during got=%b exp=11", {a_busy, b_busy}); end
    tick(); rst_sync = 0;
    total++; if ({out_valid, out_data} !== {1'b0, 32'd0}) begin bad++; $display("FAIL flush_out got=%b/%h exp=0/00000000", out_valid, out_data); end
    #1;
    total++; if ({a_busy, b_busy} !== 2'b00) begin bad++; $display("FAIL flush_busy_after got=%b exp=00", {a_busy, b_busy}); end
    out_busy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale[%0d] got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_saturation();
    int n_acc, n_res, exp_src;
    do_reset();
    n_acc = 0; n_res = 0;
    for (int c = 0; c < 26; c++) begin
      if (c < 20) begin
        if (!(a_valid && m_busy_a)) begin {a_mode, a_d0, a_d1} = rand_op(); a_valid = 1; end
        if (!(b_valid && m_busy_b)) begin {b_mode, b_d0, b_d1} = rand_op(); b_valid = 1; end
      end else begin
        a_valid = 0; b_valid = 0;
      end
      #1;
      model_comb();
      total++; if ({a_busy, b_busy} !== {m_busy_a, m_busy_b}) begin bad++; $display("FAIL sat_busy[%0d] got=%b exp=%b", c, {a_busy, b_busy}, {m_busy_a, m_busy_b}); end
      if (a_valid && !m_busy_a) n_acc++;
      if (b_valid && !m_busy_b) n_acc++;
      model_edge();
      tick();
      if (out_valid) n_res++;
      total++; if (out_valid !== m_valid) begin bad++; $display("FAIL sat_valid[%0d] got=%b exp=%b", c, out_valid, m_valid); end
      if (m_valid) begin
        total++; if ({out_source, out_data, out_flags} !== {m_src, m_data, m_flags}) begin bad++; $display("FAIL sat_result[%0d] got=%b/%h/%b exp=%b/%h/%b", c, out_source, out_data, out_flags, m_src, m_data, m_flags); end
      end
      if (c >= 1 && c < 20) begin
`ifdef EXECUTE_SHIFT_ARB_FIXED_PRIO_EN
        exp_src = 0;
`else
        exp_src = (c - 1) % 2;
`endif
        total++; if ({out_valid, out_source} !== {1'b1, 1'(exp_src)}) begin bad++; $display("FAIL sat_order[%0d] got=%b/%b exp=1/%0d", c, out_valid, out_source, exp_src); end
      end
    end
    total++; if (n_res !== n_acc) begin bad++; $display("FAIL sat_count got=%0d exp=%0d", n_res, n_acc); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!(a_valid && m_busy_a)) begin {a_mode, a_d0, a_d1} = rand_op(); a_valid = 1'($urandom_range(0, 1)); end
      if (!(b_valid && m_busy_b)) begin {b_mode, b_d0, b_d1} = rand_op(); b_valid = 1'($urandom_range(0, 1)); end
      out_busy = ($urandom_range(0, 3) == 0);
      rst_sync = ($urandom_range(0, 39) == 0);
      #1;
      model_comb();
      total++; if ({a_busy, b_busy} !== {m_busy_a, m_busy_b}) begin bad++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", c, {a_busy, b_busy}, {m_busy_a, m_busy_b}); end
      model_edge();
      tick();
      total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, out_valid, m_valid); end
      total++; if ({out_source, out_data, out_flags} !== {m_src, m_data, m_flags}) begin bad++; $display("FAIL rnd_result[%0d] got=%b/%h/%b exp=%b/%h/%b", c, out_source, out_data, out_flags, m_src, m_data, m_flags); end
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    test_reset();
    test_contention();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
